// File: rtl/mmio_port_bank.sv
// Memory-mapped I/O port bank: CHANNELS output ports (valid/ack), CHANNELS strobe-captured
// input ports and a sticky status register. Define MMIO_IRQ_EN to add an irq output and mask register.
module mmio_port_bank #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter int                CHANNELS  = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h00F0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [ADDR_W-1:0]            addr,
    input  logic                         wr_en,
    input  logic                         rd_en,
    input  logic [DATA_W-1:0]            wr_data,
    output logic                         hit,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_valid,
`ifdef MMIO_IRQ_EN
    output logic                         irq,
`endif
    output logic [CHANNELS*DATA_W-1:0]   out_data,
    output logic [CHANNELS-1:0]          out_valid,
    input  logic [CHANNELS-1:0]          out_ack,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    input  logic [CHANNELS-1:0]          in_strobe
);

    localparam int C = CHANNELS;
`ifdef MMIO_IRQ_EN
    localparam int LAST = C + 1;
    localparam logic [ADDR_W-1:0] MASK_OFF = ADDR_W'(C + 1);
`else
    localparam int LAST = C;
`endif
    localparam logic [ADDR_W-1:0] LAST_OFF = ADDR_W'(LAST);
    localparam logic [ADDR_W-1:0] STAT_OFF = ADDR_W'(C);

    logic [ADDR_W-1:0]          offset;
    logic                       rd_hit;
    logic                       wr_hit;
    logic                       stat_wr;

    logic [C-1:0][DATA_W-1:0]   out_data_reg, out_data_next;
    logic [C-1:0][DATA_W-1:0]   hold_reg, hold_next;
    logic [C-1:0]               out_valid_reg, out_valid_next;
    logic [C-1:0]               out_ovr_reg, out_ovr_next;
    logic [C-1:0]               in_full_reg, in_full_next;
    logic [C-1:0]               in_ovr_reg, in_ovr_next;
    logic [C-1:0]               wr_sel, rd_sel;
    logic [C-1:0]               clr_in, clr_out;
    logic [DATA_W-1:0]          rd_data_reg, rd_data_next;
    logic                       rd_valid_reg;
    logic [DATA_W-1:0]          status;

    // Offset is only meaningful when addr >= BASE_ADDR; the compare below guards that.
    assign offset  = addr - BASE_ADDR;
    assign hit     = (addr >= BASE_ADDR) && (offset <= LAST_OFF);
    assign rd_hit  = rd_en & hit;
    assign wr_hit  = wr_en & ~rd_en & hit;
    assign stat_wr = wr_hit && (offset == STAT_OFF);

    assign clr_in  = {C{stat_wr}} & wr_data[3*C-1:2*C];
    assign clr_out = {C{stat_wr}} & wr_data[4*C-1:3*C];

    assign status  = DATA_W'({out_ovr_reg, in_ovr_reg, out_valid_reg, in_full_reg});

    genvar gi;
    generate
        for (gi = 0; gi < C; gi++) begin : g_chan
            assign wr_sel[gi] = wr_hit && (offset == ADDR_W'(gi));
            assign rd_sel[gi] = rd_hit && (offset == ADDR_W'(gi));

            // A write alongside an ack replaces the consumed word, so it is not an overrun.
            assign out_data_next[gi]  = wr_sel[gi] ? wr_data : out_data_reg[gi];
            assign out_valid_next[gi] = wr_sel[gi] | (out_valid_reg[gi] & ~out_ack[gi]);
            assign out_ovr_next[gi]   = (wr_sel[gi] & out_valid_reg[gi] & ~out_ack[gi])
                                      | (out_ovr_reg[gi] & ~clr_out[gi]);

            // A strobe alongside a read of the same channel refills it without loss.
            assign hold_next[gi]      = in_strobe[gi] ? in_data[gi*DATA_W +: DATA_W] : hold_reg[gi];
            assign in_full_next[gi]   = in_strobe[gi] | (in_full_reg[gi] & ~rd_sel[gi]);
            assign in_ovr_next[gi]    = (in_strobe[gi] & in_full_reg[gi] & ~rd_sel[gi])
                                      | (in_ovr_reg[gi] & ~clr_in[gi]);
        end
    endgenerate

`ifdef MMIO_IRQ_EN
    logic [2*C-1:0] mask_reg, mask_next;
    logic           irq_reg, irq_next;

    assign mask_next = (wr_hit && (offset == MASK_OFF)) ? wr_data[2*C-1:0] : mask_reg;
    assign irq_next  = |(mask_reg & {~out_valid_reg, in_full_reg});
    assign irq       = irq_reg;
`endif

    always_comb begin
        rd_data_next = rd_data_reg;
        if (rd_hit) begin
            if (offset == STAT_OFF) begin
                rd_data_next = status;
`ifdef MMIO_IRQ_EN
            end else if (offset == MASK_OFF) begin
                rd_data_next = DATA_W'(mask_reg);
`endif
            end else begin
                for (int i = 0; i < C; i++) begin
                    if (offset == ADDR_W'(i)) begin
                        rd_data_next = hold_reg[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_data_reg  <= '0;
            out_valid_reg <= '0;
            out_ovr_reg   <= '0;
            hold_reg      <= '0;
            in_full_reg   <= '0;
            in_ovr_reg    <= '0;
            rd_data_reg   <= '0;
            rd_valid_reg  <= 1'b0;
`ifdef MMIO_IRQ_EN
            mask_reg      <= '0;
            irq_reg       <= 1'b0;
`endif
        end else begin
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            out_ovr_reg   <= out_ovr_next;
            hold_reg      <= hold_next;
            in_full_reg   <= in_full_next;
            in_ovr_reg    <= in_ovr_next;
            rd_data_reg   <= rd_data_next;
            rd_valid_reg  <= rd_hit;
`ifdef MMIO_IRQ_EN
            mask_reg      <= mask_next;
            irq_reg       <= irq_next;
`endif
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign rd_data   = rd_data_reg;
    assign rd_valid  = rd_valid_reg;

endmodule

// File: tb/tb_mmio_port_bank.sv
// Scoreboard bench for mmio_port_bank: directed scenario then randomized traffic against
// an array-based reference model; read responses are checked by a separate monitor.
module tb_mmio_port_bank;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int C  = 4;
    localparam logic [AW-1:0] BASE = 16'h00F0;
`ifdef MMIO_IRQ_EN
    localparam int LAST = C + 1;
`else
    localparam int LAST = C;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic [AW-1:0]     addr;
    logic              wr_en, rd_en;
    logic [DW-1:0]     wr_data;
    logic              hit;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic [C*DW-1:0]   out_data;
    logic [C-1:0]      out_valid;
    logic [C-1:0]      out_ack;
    logic [C*DW-1:0]   in_data;
    logic [C-1:0]      in_strobe;
`ifdef MMIO_IRQ_EN
    logic              irq;
`endif

    mmio_port_bank dut (
        .clock     (clock),
        .reset     (reset),
        .addr      (addr),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .wr_data   (wr_data),
        .hit       (hit),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
`ifdef MMIO_IRQ_EN
        .irq       (irq),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .in_data   (in_data),
        .in_strobe (in_strobe)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference model state
    logic [DW-1:0] m_out_d [C];
    logic          m_out_v [C];
    logic          m_out_o [C];
    logic [DW-1:0] m_hold  [C];
    logic          m_full  [C];
    logic          m_in_o  [C];
    logic [2*C-1:0] m_mask;
    logic          m_irq;

    typedef struct {
        int            tag;
        logic [DW-1:0] val;
    } rd_exp_t;
    rd_exp_t exp_q[$];

    task automatic model_clear();
        for (int c = 0; c < C; c++) begin
            m_out_d[c] = '0; m_out_v[c] = 1'b0; m_out_o[c] = 1'b0;
            m_hold[c]  = '0; m_full[c]  = 1'b0; m_in_o[c]  = 1'b0;
        end
        m_mask = '0;
        m_irq  = 1'b0;
    endtask

    function automatic logic [DW-1:0] model_status();
        logic [DW-1:0] s = '0;
        for (int c = 0; c < C; c++) begin
            s[c]       = m_full[c];
            s[C + c]   = m_out_v[c];
            s[2*C + c] = m_in_o[c];
            s[3*C + c] = m_out_o[c];
        end
        return s;
    endfunction

    function automatic logic [C*DW-1:0] chan_word(input int ch, input logic [DW-1:0] v);
        logic [C*DW-1:0] w = '0;
        w[ch*DW +: DW] = v;
        return w;
    endfunction

    task automatic check_regs();
        logic [C*DW-1:0] exp_d;
        logic [C-1:0]    exp_v;
        for (int c = 0; c < C; c++) begin
            exp_d[c*DW +: DW] = m_out_d[c];
            exp_v[c]          = m_out_v[c];
        end
        total++;
        if (out_data !== exp_d) begin
            bad++;
            $display("FAIL out_data cyc=%0d got=%h exp=%h", cyc, out_data, exp_d);
        end
        total++;
        if (out_valid !== exp_v) begin
            bad++;
            $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_v);
        end
`ifdef MMIO_IRQ_EN
        total++;
        if (irq !== m_irq) begin
            bad++;
            $display("FAIL irq cyc=%0d got=%b exp=%b", cyc, irq, m_irq);
        end
`endif
    endtask

    // One clock of stimulus: check registered outputs, drive, check hit, advance the model.
    task automatic step(input logic [AW-1:0] a, input logic w, input logic r,
                        input logic [DW-1:0] d, input logic [C-1:0] ack,
                        input logic [C-1:0] stb, input logic [C*DW-1:0] ind,
                        input logic rst);
        int  off;
        logic hm, rdh, wrh, nirq;
        @(negedge clock);
        check_regs();
        addr = a; wr_en = w; rd_en = r; wr_data = d;
        out_ack = ack; in_strobe = stb; in_data = ind; reset = rst;
        #1;
        off = int'(a) - int'(BASE);
        hm  = (off >= 0) && (off <= LAST);
        total++;
        if (hit !== hm) begin
            bad++;
            $display("FAIL hit addr=%h got=%b exp=%b", a, hit, hm);
        end
        if (rst) begin
            model_clear();
        end else begin
            rdh  = r && hm;
            wrh  = w && !r && hm;
            nirq = 1'b0;
            for (int c = 0; c < C; c++)
                nirq |= (m_mask[c] & m_full[c]) | (m_mask[C + c] & ~m_out_v[c]);
            if (rdh) begin
                rd_exp_t e;
                e.tag = cyc + 1;
                if (off == C)          e.val = model_status();
                else if (off == C + 1) e.val = DW'(m_mask);
                else                   e.val = m_hold[off];
                exp_q.push_back(e);
            end
            // Clears first so that a same-cycle set event wins.
            if (wrh && off == C)
                for (int c = 0; c < C; c++) begin
                    if (d[2*C + c]) m_in_o[c]  = 1'b0;
                    if (d[3*C + c]) m_out_o[c] = 1'b0;
                end
            if (wrh && off == C + 1) m_mask = d[2*C-1:0];
            for (int c = 0; c < C; c++) begin
                if (wrh && off == c) begin
                    if (m_out_v[c] && !ack[c]) m_out_o[c] = 1'b1;
                    m_out_d[c] = d;
                    m_out_v[c] = 1'b1;
                end else if (m_out_v[c] && ack[c]) begin
                    m_out_v[c] = 1'b0;
                end
                if (stb[c]) begin
                    if (m_full[c] && !(rdh && off == c)) m_in_o[c] = 1'b1;
                    m_hold[c] = ind[c*DW +: DW];
                    m_full[c] = 1'b1;
                end else if (rdh && off == c) begin
                    m_full[c] = 1'b0;
                end
            end
`ifdef MMIO_IRQ_EN
            m_irq = nirq;
`endif
        end
    endtask

    task automatic idle();
        step(16'h0000, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
    endtask

    // Monitor: pop one expected read per rd_valid and flag missing or extra responses.
    always @(negedge clock) begin
        if (rd_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected cyc=%0d got=%h exp=none", cyc, rd_data);
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                $display("read cyc=%0d data=%h exp=%h", cyc, rd_data, e.val);
                if (e.tag != cyc || rd_data !== e.val) begin
                    bad++;
                    $display("FAIL rd_data cyc=%0d got=%h exp=%h (due cyc %0d)", cyc, rd_data, e.val, e.tag);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
            rd_exp_t e;
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL rd_missing cyc=%0d got=rd_valid0 exp=%h", cyc, e.val);
        end
    end

    initial begin
        reset = 1'b1; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        out_ack = '0; in_strobe = '0; in_data = '0;
        model_clear();
        repeat (2) @(posedge clock);

        // Directed scenario
        step(16'h0000, 1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
        step(16'h00F0, 1'b1, 1'b0, 16'hBEEF, '0, '0, '0, 1'b0);
        repeat (3) idle();
        step(16'h0000, 1'b0, 1'b0, '0, 4'b0001, '0, '0, 1'b0);
        idle();
        step(16'h00F1, 1'b1, 1'b0, 16'h1111, '0, '0, '0, 1'b0);
        step(16'h00F1, 1'b1, 1'b0, 16'h2222, '0, '0, '0, 1'b0);
        step(16'h00F4, 1'b0, 1'b1, '0, '0, '0, '0, 1'b0);
        step(16'h00F4, 1'b1, 1'b0, 16'h2000, '0, '0, '0, 1'b0);
        step(16'h00F4, 1'b0, 1'b1, '0, '0, '0, '0, 1'b0);
        step(16'h0000, 1'b0, 1'b0, '0, '0, 4'b0100, chan_word(2, 16'h00A5), 1'b0);
        step(16'h00F4, 1'b0, 1'b1, '0, '0, '0, '0, 1'b0);
        step(16'h00F2, 1'b0, 1'b1, '0, '0, '0, '0, 1'b0);
        step(16'h00F4, 1'b0, 1'b1, '0, '0, '0, '0, 1'b0);
        step(16'h0000, 1'b0, 1'b0, '0, '0, 4'b1000, chan_word(3, 16'h0001), 1'b0);
        step(16'h0000, 1'b0, 1'b0, '0, '0, 4'b1000, chan_word(3, 16'h0002), 1'b0);
        step(16'h00F3, 1'b0, 1'b1, '0, '0, '0, '0, 1'b0);
        step(16'h00F4, 1'b0, 1'b1, '0, '0, '0, '0, 1'b0);
        step(16'h0000, 1'b0, 1'b0, '0, '0, 4'b0001, chan_word(0, 16'h0044), 1'b0);
        step(16'h00F0, 1'b0, 1'b1, '0, '0, 4'b0001, chan_word(0, 16'h0055), 1'b0);
        step(16'h00F4, 1'b1, 1'b1, 16'hFFFF, '0, '0, '0, 1'b0);
        step(16'h00EF, 1'b1, 1'b1, 16'h1234, '0, '0, '0, 1'b0);
        step(16'h00F5, 1'b1, 1'b1, 16'h1234, '0, '0, '0, 1'b0);
        step(16'h00F1, 1'b1, 1'b0, 16'h3333, '0, '0, '0, 1'b0);
        step(16'h0000, 1'b0, 1'b0, '0, '0, 4'b0100, chan_word(2, 16'h0077), 1'b0);
        step(16'h0000, 1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
        idle();
        step(16'h00F5, 1'b1, 1'b0, 16'h0001, '0, '0, '0, 1'b0);
        step(16'h0000, 1'b0, 1'b0, '0, '0, 4'b0001, chan_word(0, 16'h0099), 1'b0);
        repeat (3) idle();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            logic [AW-1:0]   a;
            logic [C*DW-1:0] ind;
            if ($urandom_range(0, 9) < 8) a = BASE - 16'd1 + AW'($urandom_range(0, LAST + 2));
            else                          a = AW'($urandom);
            for (int c = 0; c < C; c++) ind[c*DW +: DW] = DW'($urandom);
            step(a, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), DW'($urandom),
                 C'($urandom), C'($urandom & $urandom), ind, ($urandom_range(0, 299) == 0));
        end

        repeat (3) idle();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rd_drain got=%0d pending exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_port_bank.md
Name: mmio_port_bank

Overview:
Parametrised memory-mapped I/O controller placed between the PC/SP/memory block and the off-chip pins, with multiple channels.
- Decodes a small address window and claims any access inside it; the processor suppresses the RAM write on a hit.
- Provides CHANNELS independent output ports with valid/ack handshake and CHANNELS input ports with strobe-captured holding registers.
- Provides a status register with sticky overrun flags.
- Output data is held after the write; it does not return to zero.

Parameters:
DATA_W, 16, width of data bus and of every channel.
ADDR_W, 16, width of access address.
CHANNELS, 4, number of input and output channels, 1..DATA_W/4.
BASE_ADDR, 16'h00F0, address of channel 0. Channel i is at BASE_ADDR+i. Status is at BASE_ADDR+CHANNELS.

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
addr  input  ADDR_W  access address
wr_en  input  1  processor write request
rd_en  input  1  processor read request
wr_data  input  DATA_W  write data
hit  output  1  combinational; 1 when addr falls inside the decoded window, regardless of wr_en/rd_en
rd_data  output  DATA_W  registered read data
rd_valid  output  1  registered; 1 for one cycle, the cycle after an rd_en hit
out_data  output  CHANNELS*DATA_W  packed output channel registers; channel i at [i*DATA_W +: DATA_W]
out_valid  output  CHANNELS  per-channel output valid
out_ack  input  CHANNELS  per-channel consumer acknowledge
in_data  input  CHANNELS*DATA_W  packed input data
in_strobe  input  CHANNELS  per-channel capture strobe, single cycle

Behaviour:
Reset (synchronous, active-high):
- All registers, out_data, out_valid, rd_data, rd_valid, in_full, and the overrun flags clear to 0.
- A reset asserted mid-handshake drops the pending transaction with no ack required.

Decode:
- hit=1 for BASE_ADDR <= addr <= BASE_ADDR+CHANNELS.
- If wr_en and rd_en are both asserted in one cycle, the write is ignored and the read is performed.
- Access outside the window: no state change, rd_valid stays 0.

Output channel i:
- Write hit at BASE_ADDR+i: out_data[i] <= wr_data; out_valid[i] <= 1 on the next edge.
- While out_valid[i]=1 and out_ack[i]=1 at an edge: out_valid[i] <= 0; data is retained.
- Write while out_valid[i]=1: data is overwritten, valid stays 1, out_ovr[i] <= 1.
- Write and ack in the same cycle: new data is loaded, valid stays 1, no overrun flagged.
- out_ack while valid=0 is ignored.

Input channel i:
- in_strobe[i]=1: hold[i] <= in_data[i]; in_full[i] <= 1.
- Strobe while full: new data overwrites the old; in_ovr[i] <= 1.
- Read hit at BASE_ADDR+i: rd_data <= hold[i] next cycle; in_full[i] <= 0.
- Read and strobe in the same cycle: rd_data returns the old hold value, the new value is captured, in_full stays 1, no overrun flagged.
- Read when empty returns the stale hold value; in_full stays 0.

Status register (BASE_ADDR+CHANNELS), read:
- Bits [CHANNELS-1:0] = in_full.
- Bits [2C-1:C] = out_valid.
- Bits [3C-1:2C] = in_ovr.
- Bits [4C-1:3C] = out_ovr.
- Upper bits = 0.
- Reading status does not clear anything.

Status register, write:
- Write-1-to-clear on the overrun bits only; other bits are ignored.
- A set event and a clear in the same cycle: set wins.

Read latency: exactly 1 cycle. Back-to-back reads are supported every cycle.

Optional Feature:
Macro MMIO_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit, registered) and a mask register at BASE_ADDR+CHANNELS+1 (R/W, reset 0). The window extends by one address.
  - Mask bits [C-1:0] enable in_full; bits [2C-1:C] enable "output ready", i.e. ~out_valid.
  - irq = OR of the enabled sources, registered one cycle.
- Undefined: no irq port, no mask register; BASE_ADDR+CHANNELS+1 is not decoded (hit=0).

Test Plan:
Reset then write 16'hBEEF to 0xF0 -> next cycle out_data[15:0]=BEEF, out_valid[0]=1. Hold out_ack[0]=0 for 3 cycles -> valid stays 1. Pulse out_ack[0] -> valid=0, data stays BEEF.
Write 16'h1111 to 0xF1, then 16'h2222 before ack -> out_data ch1=2222, status bit 13 (out_ovr[1])=1. Write 16'h2000 to 0xF4 -> bit 13 clears.
in_strobe[2] with in_data ch2=16'h00A5 -> status bit 2=1. Read 0xF2 -> rd_valid=1 with rd_data=00A5 one cycle later, status bit 2=0.
Strobe ch3 with 16'h0001 then 16'h0002 without a read -> read 0xF3 returns 0002, in_ovr[3] (bit 11)=1.
Read 0xF0 and strobe ch0 (16'h0055) in the same cycle, hold previously 16'h0044 -> rd_data=0044, in_full[0] stays 1. Access 0x00EF -> hit=0, no rd_valid.
Assert reset while out_valid[1]=1 and in_full[2]=1 -> next cycle all outputs 0. With MMIO_IRQ_EN, write mask 16'h0001, strobe ch0 -> irq=1 two cycles after the strobe.
